// File: rtl/div_seq_if.sv
// ----------------------------------------------------------------------------
// div_seq_if: request/response bundle for the iterative divider.
//   Request : req_valid, req_ready, dividend, divisor, is_signed
//   Response: rsp_valid, rsp_ready, quotient, remainder, div_by_zero
//   master - issues requests and consumes results (execute stage / bench)
//   slave  - the divider itself
// ----------------------------------------------------------------------------
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output req_valid, dividend, divisor, is_signed, rsp_ready,
        input  req_ready, rsp_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  req_valid, dividend, divisor, is_signed, rsp_ready,
        output req_ready, rsp_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq: iterative restoring divider (RISC-V DIV/DIVU/REM/REMU semantics).
//   One trial subtraction per cycle; WIDTH cycles in BUSY for a nonzero divisor.
//   A zero divisor completes in one cycle: quotient = all ones, remainder =
//   dividend, div_by_zero = 1.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (aborts any operation in flight)
//   bus  - div_seq_if.slave: request and response valid/ready handshakes
// Configuration:
//   DIV_EARLY_OUT_EN - when defined, |divisor| > |dividend| finishes in one
//                      cycle with quotient = 0, remainder = dividend.
// ----------------------------------------------------------------------------
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst,
    div_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [WIDTH-1:0]  r_dvd, w_dvd_d;     // dividend magnitude; quotient bits shift in at LSB
    logic [WIDTH-1:0]  r_dvs, w_dvs_d;     // divisor magnitude
    logic [WIDTH-1:0]  r_part, w_part_d;   // partial remainder
    logic              r_quo_sign, w_quo_sign_d;
    logic              r_rem_sign, w_rem_sign_d;
    logic [WIDTH-1:0]  r_quo_out, w_quo_out_d;
    logic [WIDTH-1:0]  r_rem_out, w_rem_out_d;
    logic              r_dbz, w_dbz_d;

    logic              w_dvd_neg, w_dvs_neg;
    logic [WIDTH-1:0]  w_dvd_mag, w_dvs_mag;
    logic [WIDTH:0]    w_shift, w_diff;
    logic              w_ge;
    logic [WIDTH-1:0]  w_part_nxt, w_quo_nxt;
    logic [WIDTH-1:0]  w_quo_fin, w_rem_fin;
    logic              w_early;

    // Operand magnitudes; negating MIN yields MIN, which read unsigned is 2^(WIDTH-1).
    assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = w_dvs_neg ? -bus.divisor : bus.divisor;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_dvs_mag > w_dvd_mag);
`else
    assign w_early = 1'b0;
`endif

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold both the
    // shifted value and the signed trial difference.
    assign w_shift    = {r_part, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_ge       = ~w_diff[WIDTH];
    assign w_part_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt  = {r_dvd[WIDTH-2:0], w_ge};
    assign w_quo_fin  = r_quo_sign ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fin  = r_rem_sign ? -w_part_nxt : w_part_nxt;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_dvd_d      = r_dvd;
        w_dvs_d      = r_dvs;
        w_part_d     = r_part;
        w_quo_sign_d = r_quo_sign;
        w_rem_sign_d = r_rem_sign;
        w_quo_out_d  = r_quo_out;
        w_rem_out_d  = r_rem_out;
        w_dbz_d      = r_dbz;
        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    if (bus.divisor == '0) begin
                        w_state_d   = StDone;
                        w_quo_out_d = '1;
                        w_rem_out_d = bus.dividend;
                        w_dbz_d     = 1'b1;
                    end else if (w_early) begin
                        w_state_d   = StDone;
                        w_quo_out_d = '0;
                        w_rem_out_d = bus.dividend;
                        w_dbz_d     = 1'b0;
                    end else begin
                        w_state_d    = StBusy;
                        w_cnt_d      = CntW'(WIDTH);
                        w_dvd_d      = w_dvd_mag;
                        w_dvs_d      = w_dvs_mag;
                        w_part_d     = '0;
                        w_quo_sign_d = w_dvd_neg ^ w_dvs_neg;
                        w_rem_sign_d = w_dvd_neg;
                    end
                end
            end
            StBusy: begin
                w_dvd_d  = w_quo_nxt;
                w_part_d = w_part_nxt;
                w_cnt_d  = r_cnt - CntW'(1);
                if (r_cnt == CntW'(1)) begin
                    w_state_d   = StDone;
                    w_quo_out_d = w_quo_fin;
                    w_rem_out_d = w_rem_fin;
                    w_dbz_d     = 1'b0;
                end
            end
            StDone: begin
                if (bus.rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_part     <= '0;
            r_quo_sign <= 1'b0;
            r_rem_sign <= 1'b0;
            r_quo_out  <= '0;
            r_rem_out  <= '0;
            r_dbz      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_dvd      <= w_dvd_d;
            r_dvs      <= w_dvs_d;
            r_part     <= w_part_d;
            r_quo_sign <= w_quo_sign_d;
            r_rem_sign <= w_rem_sign_d;
            r_quo_out  <= w_quo_out_d;
            r_rem_out  <= w_rem_out_d;
            r_dbz      <= w_dbz_d;
        end
    end

    assign bus.req_ready   = (r_state == StIdle);
    assign bus.rsp_valid   = (r_state == StDone);
    assign bus.quotient    = r_quo_out;
    assign bus.remainder   = r_rem_out;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_seq.sv
// ----------------------------------------------------------------------------
// tb_div_seq: self-checking bench for div_seq (WIDTH = 32).
//   Directed cases plus randomized operands against an arithmetic reference.
// ----------------------------------------------------------------------------
module tb_div_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (SV division truncates toward zero,
    // remainder takes the dividend's sign, as RISC-V requires).
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
        longint sa, sb, mq, mr, ma, mb;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1; lat = 1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            mq = sa / sb;
            mr = sa % sb;
            q  = mq[W-1:0];
            r  = mr[W-1:0];
            z  = 1'b0;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
            lat = (mb > ma) ? 1 : W + 1;
`else
            lat = (mb > ma) ? W + 1 : W + 1;
`endif
        end
    endtask

    // Issue one request and wait for rsp_valid; leaves the result pending.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input bit noisy);
        logic [W-1:0] eq, er;
        logic         ez;
        int           elat, lat;
        model(a, b, s, eq, er, ez, elat);
        chk({tag, " req_ready idle"}, 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                // Operand changes after acceptance must not matter.
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
                bus.is_signed = 1'($urandom);
            end
            if (bus.rsp_valid || lat >= 200) break;
            if (noisy && lat >= 3 && lat <= 6) begin
                bus.req_valid = 1'b1;
                chk({tag, " req_ready busy"}, 64'(bus.req_ready), 64'(0));
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " quotient"}, 64'(bus.quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(bus.remainder), 64'(er));
        chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(ez));
    endtask

    task automatic pop(input string tag);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, " rsp_valid after pop"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, " req_ready after pop"}, 64'(bus.req_ready), 64'(1));
    endtask

    initial begin
        logic [W-1:0] hq, hr, a, b;
        logic         hz, s;
        int           kind;

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 64'(bus.req_ready), 64'(1));
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset quotient", 64'(bus.quotient), 64'(0));
        chk("reset remainder", 64'(bus.remainder), 64'(0));
        chk("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, with literal checks on the headline values.
        do_op("u 100/7", 32'd100, 32'd7, 1'b0, 1'b1);
        chk("u 100/7 q lit", 64'(bus.quotient), 64'(14));
        chk("u 100/7 r lit", 64'(bus.remainder), 64'(2));
        pop("u 100/7");

        do_op("s -100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
        chk("s -100/7 q lit", 64'(bus.quotient), 64'(32'hFFFF_FFF2));
        chk("s -100/7 r lit", 64'(bus.remainder), 64'(32'hFFFF_FFFE));
        pop("s -100/7");

        do_op("s 100/-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0);
        chk("s 100/-7 q lit", 64'(bus.quotient), 64'(32'hFFFF_FFF2));
        pop("s 100/-7");

        do_op("u div0", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        pop("u div0");
        do_op("s div0", 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        chk("s div0 q lit", 64'(bus.quotient), 64'(32'hFFFF_FFFF));
        pop("s div0");

        do_op("s overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("s overflow q lit", 64'(bus.quotient), 64'(32'h8000_0000));
        pop("s overflow");

        do_op("5/9", 32'd5, 32'd9, 1'b0, 1'b0);
        chk("5/9 q lit", 64'(bus.quotient), 64'(0));
        chk("5/9 r lit", 64'(bus.remainder), 64'(5));
        pop("5/9");

        // Backpressure: result held, no request accepted while pending.
        do_op("bp", 32'd1000, 32'd33, 1'b0, 1'b0);
        hq = bus.quotient;
        hr = bus.remainder;
        hz = bus.div_by_zero;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.dividend  = $urandom;
            bus.divisor   = 32'd0;
            @(posedge clk); #1;
            chk("bp rsp_valid held", 64'(bus.rsp_valid), 64'(1));
            chk("bp req_ready low", 64'(bus.req_ready), 64'(0));
            chk("bp quotient stable", 64'(bus.quotient), 64'(hq));
            chk("bp remainder stable", 64'(bus.remainder), 64'(hr));
            chk("bp dbz stable", 64'(bus.div_by_zero), 64'(hz));
        end
        bus.req_valid = 1'b0;
        pop("bp");

        // Reset during a division aborts it.
        bus.req_valid = 1'b1;
        bus.dividend  = 32'd77777;
        bus.divisor   = 32'd3;
        bus.is_signed = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst req_ready", 64'(bus.req_ready), 64'(1));
        chk("midrst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst quotient", 64'(bus.quotient), 64'(0));
        chk("midrst remainder", 64'(bus.remainder), 64'(0));
        chk("midrst div_by_zero", 64'(bus.div_by_zero), 64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        do_op("post rst", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        chk("post rst q lit", 64'(bus.quotient), 64'(32'h0FFF_FFFF));
        chk("post rst r lit", 64'(bus.remainder), 64'(32'hF));
        pop("post rst");

        // Randomized operands.
        for (int i = 0; i < 40; i++) begin
            a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            kind = $urandom_range(0, 5);
            case (kind)
                0:       b = '0;
                1:       b = '1;
                2:       b = 32'($urandom);
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                4:       b = 32'($urandom_range(1, 20));
                default: b = a >> $urandom_range(0, 4);
            endcase
            s = 1'($urandom);
            do_op($sformatf("rnd%0d", i), a, b, s, 1'($urandom));
            pop($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
